data_mem_lsu: RTL and testbench
===============================

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default `_MEM_ADDR_WIDTH_, is the word-address width of the data memory port.
REQ-002 Parameter DATA_WIDTH, default `_MEM_DATA_WIDTH_ (32), is the data-bus and memory-word width.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 Port list SHALL be:
  clk  input  1  rising-edge clock
  reset  input  1  asynchronous active-high reset
  i_Req  input  1  core access request
  i_We  input  1  1 = store, 0 = load
  i_Funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
  i_Addr  input  32  byte address
  i_WData  input  DATA_WIDTH  store data, right-aligned
  o_Ready  output  1  block idle, request accepted this cycle
  o_Done  output  1  one-cycle completion pulse
  o_RData  output  DATA_WIDTH  extended load result
  o_Misalign  output  1  misaligned-access flag, valid with o_Done
  o_MemAddr  output  MEM_ADDR_WIDTH  word address to data memory
  o_MemData  output  DATA_WIDTH  write word to data memory
  o_MemWrEn  output  1  data memory write enable
  i_MemData  input  DATA_WIDTH  combinational read word from data memory

Function
REQ-005 Block SHALL be the initiator for a word-addressed memory with a combinational read and a write committed on the rising clock edge when write enable is high.
REQ-006 States SHALL be IDLE, RD, WR, RESP; o_Ready = 1 only in IDLE.
REQ-007 Request SHALL be accepted on a clock edge where i_Req & o_Ready; i_We, i_Funct3, i_Addr and i_WData SHALL be latched at that edge and ignored afterwards.
REQ-008 o_MemAddr SHALL equal latched i_Addr[MEM_ADDR_WIDTH+1:2] in RD and WR.
REQ-009 Transitions: load IDLE->RD->RESP; SW IDLE->WR->RESP; SB/SH IDLE->RD->WR->RESP; RESP->IDLE always.
REQ-010 In RD, i_MemData SHALL be captured into an internal word register at the clock edge.
REQ-011 In WR, o_MemWrEn SHALL be 1 for exactly one cycle; o_MemData SHALL be the captured word with the target byte/halfword lane(s) replaced by i_WData[7:0]/[15:0], or i_WData for SW.
REQ-012 Lane selection SHALL use i_Addr[1:0] for bytes and i_Addr[1] for halfwords.
REQ-013 Loads SHALL extract the lane and sign-extend (B, H) or zero-extend (BU, HU); o_RData SHALL update on entry to RESP and hold until the next completed load.
REQ-014 o_Done SHALL be 1 only in RESP; latency from acceptance to o_Done: load 2 cycles, SW 2, SB/SH 3.
REQ-015 Funct3 codes 011, 110, 111 SHALL be executed as word accesses.
REQ-016 o_MemWrEn SHALL be 0 in every state except WR.

Reset
REQ-017 Reset SHALL force state IDLE, o_Ready=1, o_Done=0, o_RData=0, o_Misalign=0, o_MemWrEn=0, o_MemAddr=0, o_MemData=0 immediately, independent of clk.
REQ-018 Reset asserted in RD or WR SHALL abort the access with no memory write after reset deasserts and no o_Done pulse.

Configuration
REQ-019 Macro LSU_MISALIGN_TRAP_EN, when defined: halfword with i_Addr[0]=1 or word with i_Addr[1:0]!=0 SHALL go IDLE->RESP, o_Misalign=1 with o_Done, no memory access, o_RData unchanged.
REQ-020 Without LSU_MISALIGN_TRAP_EN: o_Misalign SHALL be tied 0 and misaligned addresses SHALL be truncated to natural alignment (low bits ignored).

Verification
REQ-021 Mem[1]=32'h8899AABB; LB addr 0x5 -> o_Done 2 cycles after acceptance, o_RData=32'hFFFFFFAA; LBU same addr -> 32'h000000AA.
REQ-022 Mem[1]=32'h8899AABB; SB addr 0x7 data 32'h00000011 -> o_MemWrEn high exactly one cycle, Mem[1]=32'h1199AABB, o_Done 3 cycles after acceptance.
REQ-023 SW addr 0x8 data 32'hDEADBEEF -> no RD state, Mem[2]=32'hDEADBEEF, o_Done 2 cycles after acceptance; LHU addr 0xA -> 32'h0000DEAD.
REQ-024 Macro defined, LH addr 0x3 -> o_Done and o_Misalign 1 cycle after acceptance, o_MemWrEn never 1; macro undefined, same access -> reads halfword at 0x2.
REQ-025 i_Req held high through SB/SH access -> o_Ready low until return to IDLE, no second access accepted early; new request accepted on the first IDLE cycle.
REQ-026 Reset pulsed while in WR of SH addr 0x4 -> o_MemWrEn drops immediately, Mem[1] unchanged, no o_Done, o_Ready=1.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Load/store unit driving a word-addressed data memory (combinational read, clocked write).
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete at once with o_Misalign set.
`ifndef _MEM_ADDR_WIDTH_
`define _MEM_ADDR_WIDTH_ 10
`endif
`ifndef _MEM_DATA_WIDTH_
`define _MEM_DATA_WIDTH_ 32
`endif

module data_mem_lsu #(
  parameter int MEM_ADDR_WIDTH = `_MEM_ADDR_WIDTH_,
  parameter int DATA_WIDTH     = `_MEM_DATA_WIDTH_
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_Req,
  input  logic                      i_We,
  input  logic [2:0]                i_Funct3,
  input  logic [31:0]               i_Addr,
  input  logic [DATA_WIDTH-1:0]     i_WData,
  output logic                      o_Ready,
  output logic                      o_Done,
  output logic [DATA_WIDTH-1:0]     o_RData,
  output logic                      o_Misalign,
  output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
  output logic [DATA_WIDTH-1:0]     o_MemData,
  output logic                      o_MemWrEn,
  input  logic [DATA_WIDTH-1:0]     i_MemData
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t                state;
  logic                  we_p0;
  logic                  uns_p0;
  logic [1:0]            size_p0;
  logic [1:0]            off_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [DATA_WIDTH-1:0] word_p1;
  logic [1:0]            req_size;
  logic                  req_uns;
  logic                  req_trap;
  logic                  unused_addr_hi;

  // Codes 011/110/111 fall through to word accesses.
  function automatic logic [1:0] decode_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            off,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    return uns ? {{(DATA_WIDTH-8){1'b0}}, b}  : {{(DATA_WIDTH-8){b[7]}}, b};
      SZ_H:    return uns ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_store(
    input logic [DATA_WIDTH-1:0] word,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [1:0]            off,
    input logic [1:0]            size
  );
    logic [DATA_WIDTH-1:0] r;
    r = word;
    case (size)
      SZ_B:    r[{off, 3'b000} +: 8]     = wdata[7:0];
      SZ_H:    r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign req_size       = decode_size(i_Funct3);
  assign req_uns        = i_Funct3[2];
  assign unused_addr_hi = ^i_Addr[31:MEM_ADDR_WIDTH+2];
  assign o_MemData      = word_p1;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign req_trap   = ((req_size == SZ_H) && i_Addr[0]) ||
                      ((req_size == SZ_W) && (i_Addr[1:0] != 2'b00));
  assign o_Misalign = misalign_q;
`else
  assign req_trap   = 1'b0;
  assign o_Misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      o_Ready   <= 1'b1;
      o_Done    <= 1'b0;
      o_MemWrEn <= 1'b0;
      o_RData   <= '0;
      o_MemAddr <= '0;
      word_p1   <= '0;
      we_p0     <= 1'b0;
      uns_p0    <= 1'b0;
      size_p0   <= SZ_W;
      off_p0    <= 2'b00;
      wdata_p0  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      o_Done    <= 1'b0;
      o_MemWrEn <= 1'b0;
      case (state)
        // p0: request latched; inputs are ignored from here on
        IDLE: begin
          if (i_Req) begin
            we_p0     <= i_We;
            uns_p0    <= req_uns;
            size_p0   <= req_size;
            off_p0    <= i_Addr[1:0];
            wdata_p0  <= i_WData;
            o_MemAddr <= i_Addr[MEM_ADDR_WIDTH+1:2];
            o_Ready   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= req_trap;
`endif
            if (req_trap) begin
              state  <= RESP;
              o_Done <= 1'b1;
            end else if (i_We && (req_size == SZ_W)) begin
              state     <= WR;
              o_MemWrEn <= 1'b1;
              word_p1   <= i_WData;
            end else begin
              state <= RD;
            end
          end
        end
        // p1: read word captured; sub-word stores merge into it before WR
        RD: begin
          if (we_p0) begin
            word_p1   <= merge_store(i_MemData, wdata_p0, off_p0, size_p0);
            state     <= WR;
            o_MemWrEn <= 1'b1;
          end else begin
            word_p1 <= i_MemData;
            o_RData <= load_extend(i_MemData, off_p0, size_p0, uns_p0);
            state   <= RESP;
            o_Done  <= 1'b1;
          end
        end
        WR: begin
          state  <= RESP;
          o_Done <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_Ready <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: byte-level memory model plus directed literal checks.
module tb_data_mem_lsu;
  localparam int MAW = 8;
  localparam int DW  = 32;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           i_Req = 1'b0;
  logic           i_We = 1'b0;
  logic [2:0]     i_Funct3 = 3'b000;
  logic [31:0]    i_Addr = '0;
  logic [DW-1:0]  i_WData = '0;
  logic           o_Ready;
  logic           o_Done;
  logic [DW-1:0]  o_RData;
  logic           o_Misalign;
  logic [MAW-1:0] o_MemAddr;
  logic [DW-1:0]  o_MemData;
  logic           o_MemWrEn;
  logic [DW-1:0]  i_MemData;

  logic [31:0] mem [256];
  logic [31:0] model_mem [256];
  logic        init_mem = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  int          exp_a = -100;
  int          exp_lat = 0;
  int          exp_wr = -1;
  int          exp_widx = 0;
  bit          exp_mis = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_wword = '0;
  logic [31:0] model_rdata = '0;
  int          saved_idx = 0;
  logic [31:0] saved_word = '0;
  int          cmp_done;
  bit          cmp_busy;

  data_mem_lsu #(.MEM_ADDR_WIDTH(MAW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .i_Req(i_Req), .i_We(i_We), .i_Funct3(i_Funct3),
    .i_Addr(i_Addr), .i_WData(i_WData), .o_Ready(o_Ready), .o_Done(o_Done),
    .o_RData(o_RData), .o_Misalign(o_Misalign), .o_MemAddr(o_MemAddr),
    .o_MemData(o_MemData), .o_MemWrEn(o_MemWrEn), .i_MemData(i_MemData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'hC0DE8123;
      1:       return 32'h8899AABB;
      default: return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endcase
  endfunction

  assign i_MemData = mem[o_MemAddr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (o_MemWrEn) begin
      mem[o_MemAddr] <= o_MemData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: decides latency, write word and load result from the access rules.
  task automatic model_expect(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int a);
    int nb, a2, base, idx;
    bit uns;
    logic [31:0] w;
    longint v;
    nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    uns  = f3[2] && (nb < 4);
    a2   = int'(addr[1:0]);
    base = a2 - (a2 % nb);
    idx  = int'((addr >> 2) & 32'hFF);
    exp_a    = a;
    exp_widx = idx;
    exp_mis  = TRAP_EN && ((a2 % nb) != 0);
    exp_wr   = -1;
    if (exp_mis) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      w = model_mem[idx];
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(w[8*(base+i) +: 8]) << (8*i));
      if (!uns && nb < 4 && v >= (longint'(1) << (8*nb-1))) v = v - (longint'(1) << (8*nb));
      model_rdata = v[31:0];
    end else begin
      exp_lat    = (nb == 4) ? 2 : 3;
      saved_idx  = idx;
      saved_word = model_mem[idx];
      w = model_mem[idx];
      for (int i = 0; i < nb; i++) w[8*(base+i) +: 8] = wd[8*i +: 8];
      model_mem[idx] = w;
      exp_wword = w;
      exp_wr    = a + exp_lat - 2;
    end
    exp_rdata = model_rdata;
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      cmp_done = exp_a + exp_lat - 1;
      cmp_busy = (exp_lat > 0) && (cyc >= exp_a) && (cyc <= cmp_done);
      chk("ready", 32'(o_Ready), 32'(!cmp_busy));
      chk("done", 32'(o_Done), 32'(cyc == cmp_done));
      chk("memwren", 32'(o_MemWrEn), 32'(cyc == exp_wr));
      if (cmp_busy && !exp_mis && cyc <= cmp_done - 1)
        chk("memaddr", 32'(o_MemAddr), 32'(exp_widx));
      if (cyc == exp_wr) chk("memdata", o_MemData, exp_wword);
      if (cyc == cmp_done) chk("misalign", 32'(o_Misalign), 32'(exp_mis));
      if (exp_lat > 0 && cyc >= cmp_done) chk("rdata", o_RData, exp_rdata);
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!o_Ready && guard < 12) begin
      @(negedge clk);
      guard++;
    end
    if (!o_Ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: o_Ready=%b expected 1", o_Ready);
    end
    model_expect(we, f3, addr, wd, cyc + 1);
    i_Req = 1'b1; i_We = we; i_Funct3 = f3; i_Addr = addr; i_WData = wd;
    @(posedge clk);
    #1;
    i_Req    = hold;
    i_We     = 1'($urandom);
    i_Funct3 = 3'($urandom);
    i_Addr   = $urandom;
    i_WData  = $urandom;
  endtask

  task automatic wait_done(output int lat, output int pulses);
    lat = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      lat++;
      if (o_MemWrEn) pulses++;
    end while (!o_Done && lat < 12);
    if (!o_Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: o_Done=%b expected 1 within %0d cycles", o_Done, lat);
    end
  endtask

  logic [67:0] vt [14] = '{
    {1'b0, 3'b001, 32'h0000_0000, 32'h0},
    {1'b0, 3'b000, 32'h0000_0001, 32'h0},
    {1'b0, 3'b000, 32'h0000_0000, 32'h0},
    {1'b0, 3'b101, 32'h0000_0002, 32'h0},
    {1'b1, 3'b011, 32'h0000_000C, 32'hCAFEF00D},
    {1'b0, 3'b110, 32'h0000_000C, 32'h0},
    {1'b0, 3'b111, 32'h0000_000E, 32'h0},
    {1'b1, 3'b100, 32'h0000_000D, 32'h0000_005A},
    {1'b0, 3'b010, 32'h0000_000C, 32'h0},
    {1'b1, 3'b010, 32'h0000_0011, 32'h0123_4567},
    {1'b0, 3'b010, 32'h0000_0010, 32'h0},
    {1'b1, 3'b001, 32'h0000_000D, 32'h0000_7777},
    {1'b0, 3'b010, 32'h0000_000C, 32'h0},
    {1'b0, 3'b001, 32'h0000_001F, 32'h0}
  };

  initial begin
    #50000;
    $display("FAIL watchdog: time %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, pul;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", 32'(o_Ready), 32'd1);
    chk("rst_done", 32'(o_Done), 32'd0);
    chk("rst_rdata", o_RData, 32'd0);
    chk("rst_misalign", 32'(o_Misalign), 32'd0);
    chk("rst_memwren", 32'(o_MemWrEn), 32'd0);
    chk("rst_memaddr", 32'(o_MemAddr), 32'd0);
    chk("rst_memdata", o_MemData, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    init_mem = 1'b0;
    chk_en = 1'b1;

    issue(1'b0, 3'b000, 32'h5, 32'h0, 1'b0); wait_done(lat, pul);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_rdata", o_RData, 32'hFFFFFFAA);
    issue(1'b0, 3'b100, 32'h5, 32'h0, 1'b0); wait_done(lat, pul);
    chk("lbu_rdata", o_RData, 32'h000000AA);

    issue(1'b1, 3'b000, 32'h7, 32'h0000_0011, 1'b0); wait_done(lat, pul);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_wr_pulses", 32'(pul), 32'd1);
    chk("sb_mem1", mem[1], 32'h1199AABB);

    issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0); wait_done(lat, pul);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_wr_pulses", 32'(pul), 32'd1);
    chk("sw_mem2", mem[2], 32'hDEADBEEF);
    issue(1'b0, 3'b101, 32'hA, 32'h0, 1'b0); wait_done(lat, pul);
    chk("lhu_rdata", o_RData, 32'h0000DEAD);

    issue(1'b0, 3'b001, 32'h3, 32'h0, 1'b0); wait_done(lat, pul);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lh_mis_lat", 32'(lat), 32'd1);
    chk("lh_mis_flag", 32'(o_Misalign), 32'd1);
    chk("lh_mis_pulses", 32'(pul), 32'd0);
    chk("lh_mis_rdata", o_RData, 32'h0000DEAD);
`else
    chk("lh_trunc_lat", 32'(lat), 32'd2);
    chk("lh_trunc_rdata", o_RData, 32'hFFFFC0DE);
    chk("lh_trunc_flag", 32'(o_Misalign), 32'd0);
`endif

    issue(1'b1, 3'b001, 32'h6, 32'hABCD1234, 1'b1); wait_done(lat, pul);
    chk("hold_sh_lat", 32'(lat), 32'd3);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b0); wait_done(lat, pul);
    chk("hold_lw_lat", 32'(lat), 32'd2);
    chk("hold_lw_rdata", o_RData, 32'h1234AABB);

    for (int k = 0; k < 14; k++) begin
      issue(vt[k][67], vt[k][66:64], vt[k][63:32], vt[k][31:0], 1'b0);
      wait_done(lat, pul);
    end

    issue(1'b1, 3'b001, 32'h4, 32'h0000_FFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_wren_before", 32'(o_MemWrEn), 32'd1);
    #1;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_wren", 32'(o_MemWrEn), 32'd0);
    chk("abort_ready", 32'(o_Ready), 32'd1);
    chk("abort_done", 32'(o_Done), 32'd0);
    #1;
    reset = 1'b0;
    model_mem[saved_idx] = saved_word;
    model_rdata = '0;
    exp_rdata = '0;
    exp_a = -100;
    exp_lat = 0;
    exp_wr = -1;
    exp_mis = 1'b0;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_mem1", mem[1], 32'h1234AABB);

    issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b0); wait_done(lat, pul);
    chk("post_abort_lw", o_RData, 32'h1234AABB);

    for (int i = 0; i < 8; i++) chk($sformatf("mem_final%0d", i), mem[i], model_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
